// File: rtl/csr_idle_ctrl_if.sv
// csr_idle_ctrl_if: bundle between the IDLE sequencer and its CSR/pipeline peers.
//   master : drives IdleCommit, IdlePc, IntPending, PipeEmpty; observes status
//   slave  : the sequencer (csr_idle_ctrl)
// Optional: CSR_IDLE_CNT_EN adds IdleCycleCnt (CNT_W bits).
interface csr_idle_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
);
    logic            IdleCommit;
    logic [PC_W-1:0] IdlePc;
    logic            IntPending;
    logic            PipeEmpty;
    logic            IdleFlashAble;
    logic            IDleStopAble;
    logic            WakeValid;
    logic [PC_W-1:0] WakePc;
    logic            IdleBusy;
    logic            DrainTimeout;
`ifdef CSR_IDLE_CNT_EN
    logic [CNT_W-1:0] IdleCycleCnt;

    modport master (
        output IdleCommit, IdlePc, IntPending, PipeEmpty,
        input  IdleFlashAble, IDleStopAble, WakeValid, WakePc, IdleBusy, DrainTimeout,
        input  IdleCycleCnt
    );
    modport slave (
        input  IdleCommit, IdlePc, IntPending, PipeEmpty,
        output IdleFlashAble, IDleStopAble, WakeValid, WakePc, IdleBusy, DrainTimeout,
        output IdleCycleCnt
    );
`else
    modport master (
        output IdleCommit, IdlePc, IntPending, PipeEmpty,
        input  IdleFlashAble, IDleStopAble, WakeValid, WakePc, IdleBusy, DrainTimeout
    );
    modport slave (
        input  IdleCommit, IdlePc, IntPending, PipeEmpty,
        output IdleFlashAble, IDleStopAble, WakeValid, WakePc, IdleBusy, DrainTimeout
    );
`endif

    if (CNT_W == 0) begin : g_cnt_w_chk
        $error("csr_idle_ctrl_if: CNT_W must be at least 1");
    end
endinterface

// File: rtl/csr_idle_ctrl.sv
// csr_idle_ctrl: CSR-side sequencer for the LoongArch IDLE instruction.
//   On IDLE retirement it flushes younger work (IdleFlashAble), waits for the
//   pipeline to drain (bounded by DRAIN_MAX), stops the core (IDleStopAble) and
//   restarts it at IdlePc+4 with a one-cycle WakeValid pulse once an interrupt
//   is pending.
// Ports:
//   Clk   core clock
//   Rest  asynchronous active-low reset
//   bus   csr_idle_ctrl_if.slave
//         in : IdleCommit, IdlePc, IntPending, PipeEmpty
//         out: IdleFlashAble, IDleStopAble, WakeValid, WakePc, IdleBusy, DrainTimeout,
//              IdleCycleCnt (only with CSR_IDLE_CNT_EN)
// Optional feature macro: CSR_IDLE_CNT_EN (saturating count of STOP cycles).
// All outputs are decoded from registers only (Moore).
module csr_idle_ctrl #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DRAIN_MAX = 64,
    parameter int unsigned CNT_W     = 32
) (
    input logic             Clk,
    input logic             Rest,
    csr_idle_ctrl_if.slave  bus
);
    localparam int unsigned DW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StFlush = 2'b01,
        StStop  = 2'b10,
        StWake  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_timeout_set;
    logic            w_enter_flush;
    logic [PC_W-1:0] r_wake_pc;
    logic [DW-1:0]   r_drain_cnt;
    logic            r_drain_to;

    assign w_enter_flush = (r_state == StRun) && bus.IdleCommit;

    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_set = 1'b0;
        unique case (r_state)
            StRun: begin
                if (bus.IdleCommit) w_state_nxt = StFlush;
            end
            StFlush: begin
                // A drained pipeline wins over the timeout in the same cycle.
                if (bus.PipeEmpty) begin
                    w_state_nxt = bus.IntPending ? StWake : StStop;
                end else if (r_drain_cnt == DW'(DRAIN_MAX - 1)) begin
                    w_state_nxt   = StStop;
                    w_timeout_set = 1'b1;
                end
            end
            StStop: begin
                if (bus.IntPending) w_state_nxt = StWake;
            end
            StWake: begin
                w_state_nxt = StRun;
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state     <= StRun;
            r_wake_pc   <= '0;
            r_drain_cnt <= '0;
            r_drain_to  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter_flush) begin
                r_wake_pc   <= bus.IdlePc + PC_W'(4);
                r_drain_cnt <= '0;
            end else if (r_state == StFlush) begin
                // May wrap on the final FLUSH cycle; the value is unused after leaving FLUSH.
                r_drain_cnt <= r_drain_cnt + DW'(1);
            end
            if (w_timeout_set) r_drain_to <= 1'b1;
        end
    end

    assign bus.IdleFlashAble = (r_state == StFlush);
    assign bus.IDleStopAble  = (r_state == StStop);
    assign bus.WakeValid     = (r_state == StWake);
    assign bus.IdleBusy      = (r_state != StRun);
    assign bus.WakePc        = r_wake_pc;
    assign bus.DrainTimeout  = r_drain_to;

`ifdef CSR_IDLE_CNT_EN
    logic [CNT_W-1:0] r_idle_cnt;

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_idle_cnt <= '0;
        end else if (w_enter_flush) begin
            r_idle_cnt <= '0;
        end else if ((r_state == StStop) && (r_idle_cnt != {CNT_W{1'b1}})) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    assign bus.IdleCycleCnt = r_idle_cnt;
`endif

    if (DRAIN_MAX < 2 || PC_W < 3 || CNT_W == 0) begin : g_param_chk
        $error("csr_idle_ctrl: need DRAIN_MAX >= 2, PC_W >= 3, CNT_W >= 1");
    end
endmodule
